// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode constants, receiver FSM state type, baud divider helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  // Clocks per oversample tick; integer truncation.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk o_tick every DIV clocks, phase reset by i_restart.
// Latency: first tick DIV clocks after i_restart drops.
// Backpressure: none; free-running while i_restart is low.
// Ports: clk, rst (sync, active-high), i_restart (hold counter at 0), o_tick (registered pulse).
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int DIV_C = (DIV < 1) ? 1 : DIV;
  localparam int CW    = (DIV_C > 1) ? $clog2(DIV_C) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_C - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      o_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 2-of-3 majority sampling and a valid/ready output register.
// Latency: word committed one clk after the last stop-bit evaluation (mid stop bit).
// Backpressure: a frame completing while the output is held drops and pulses err_overrun.
// Ports: clk, rst (sync, active-high), serial_in (async line), out_data/out_valid/out_ready,
//        err_frame/err_parity (qualified by out_valid), err_overrun (pulse), rx_busy.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_frame,
  output logic                 err_parity,
  output logic                 err_overrun,
  output logic                 rx_busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);

  // Tick indices within one bit period.
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_EV   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  rx_state_t            r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_armed;
  logic [TW-1:0]        r_tick_cnt;
  logic                 r_s0;
  logic                 r_s1;
  logic [3:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frm_err;
  logic                 r_par_err;

  logic w_restart;
  logic w_tick;
  logic w_eval;
  logic w_maj;
  logic w_par_exp;
  logic w_accept;

  // Divider is held while idle so each frame's ticks are phase-aligned to its start edge.
  assign w_restart = (r_state == S_IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // The third sample is the live synchronised value at the evaluation tick.
  assign w_eval    = w_tick && (r_tick_cnt == T_EV);
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
  assign w_par_exp = (PARITY == PAR_EVEN) ? ^r_shift : ~^r_shift;
  assign w_accept  = !out_valid || out_ready;
  assign rx_busy   = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_armed     <= 1'b0;
      r_tick_cnt  <= '0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_bit_cnt   <= '0;
      r_stop_cnt  <= 1'b0;
      r_shift     <= '0;
      r_frm_err   <= 1'b0;
      r_par_err   <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      err_frame   <= 1'b0;
      err_parity  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      r_sync1     <= serial_in;
      r_sync2     <= r_sync1;
      err_overrun <= 1'b0;

      // A commit later in this block overrides the handshake clear.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (w_tick) begin
        r_tick_cnt <= (r_tick_cnt == T_LAST) ? '0 : r_tick_cnt + 1'b1;
        if (r_tick_cnt == T_S0) r_s0 <= r_sync2;
        if (r_tick_cnt == T_S1) r_s1 <= r_sync2;
      end

      unique case (r_state)
        S_IDLE: begin
          r_tick_cnt <= '0;
          // Arming requires a high line first, so a held break yields a single frame.
          if (r_sync2) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_armed    <= 1'b0;
            r_state    <= S_START;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_frm_err  <= 1'b0;
            r_par_err  <= 1'b0;
          end
        end

        S_START: begin
          if (w_eval) begin
            r_state <= w_maj ? S_IDLE : S_DATA;
          end
        end

        S_DATA: begin
          if (w_eval) begin
            r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
            end
          end
        end

        S_PARITY: begin
          if (w_eval) begin
            r_par_err <= (w_maj != w_par_exp);
            r_state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (w_eval) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
            if (!w_maj) r_frm_err <= 1'b1;
            if (r_stop_cnt == STOP_LAST) begin
              r_state <= S_IDLE;
              if (w_accept) begin
                out_data   <= r_shift;
                err_frame  <= r_frm_err | ~w_maj;
                err_parity <= r_par_err;
                out_valid  <= 1'b1;
              end else begin
                err_overrun <= 1'b1;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: three receiver configurations (8N1, 8E1, 7O2) driven by a
// bit-level line driver; expected words come from the frame contents sent.
// Inputs change 1 time unit after the rising edge; handshakes are sampled on the falling edge.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] ser;
  logic [2:0] rdy;
  logic [2:0] vld;
  logic [2:0] fe;
  logic [2:0] pe;
  logic [2:0] ovr;
  logic [2:0] busy;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [6:0] d2;

  // Per-instance configuration: data bits, parity mode, stop bits, clocks per bit.
  localparam int DBW  [3] = '{8, 8, 7};
  localparam int PARM [3] = '{0, 2, 1};
  localparam int STB  [3] = '{1, 1, 2};
  localparam int BT   [3] = '{32, 32, 24};

  int n_vec = 0;
  int n_err = 0;
  int rxq [3][$];
  int ovr_cnt [3] = '{0, 0, 0};

  uart_rx_param #(.CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
    .clk(clk), .rst(rst), .serial_in(ser[0]), .out_data(d0), .out_valid(vld[0]),
    .out_ready(rdy[0]), .err_frame(fe[0]), .err_parity(pe[0]), .err_overrun(ovr[0]),
    .rx_busy(busy[0]));

  uart_rx_param #(.CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)) u1 (
    .clk(clk), .rst(rst), .serial_in(ser[1]), .out_data(d1), .out_valid(vld[1]),
    .out_ready(rdy[1]), .err_frame(fe[1]), .err_parity(pe[1]), .err_overrun(ovr[1]),
    .rx_busy(busy[1]));

  uart_rx_param #(.CLK_FREQ(2_400_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2), .OVERSAMPLE(8)) u2 (
    .clk(clk), .rst(rst), .serial_in(ser[2]), .out_data(d2), .out_valid(vld[2]),
    .out_ready(rdy[2]), .err_frame(fe[2]), .err_parity(pe[2]), .err_overrun(ovr[2]),
    .rx_busy(busy[2]));

  function automatic int dout(input int u);
    case (u)
      0:       return int'(d0);
      1:       return int'(d1);
      default: return int'(d2);
    endcase
  endfunction

  // Delivered words are packed as data | frame_err<<9 | parity_err<<10.
  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 3; u++) begin
        if (vld[u] && rdy[u]) rxq[u].push_back(dout(u) | (int'(fe[u]) << 9) | (int'(pe[u]) << 10));
        if (ovr[u]) ovr_cnt[u]++;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full frame onto instance u's line, then leaves it idle high.
  task automatic send_frame(input int u, input int data, input bit pflip,
                            input bit sbad, input int sbad_idx);
    bit p;
    ser[u] = 1'b0;
    step(BT[u]);
    for (int i = 0; i < DBW[u]; i++) begin
      ser[u] = 1'((data >> i) & 1);
      step(BT[u]);
    end
    if (PARM[u] != 0) begin
      p = 1'($countones(data & ((1 << DBW[u]) - 1)) & 1);
      if (PARM[u] == 1) p = !p;
      if (pflip) p = !p;
      ser[u] = p;
      step(BT[u]);
    end
    for (int s = 0; s < STB[u]; s++) begin
      ser[u] = !(sbad && (s == sbad_idx));
      step(BT[u]);
    end
    ser[u] = 1'b1;
  endtask

  task automatic expect_frame(input int u, input int data, input bit efe,
                              input bit epe, input string tag);
    int n = 0;
    int got;
    while (rxq[u].size() == 0 && n < 500) begin
      step(1);
      n++;
    end
    chk({tag, ".count"}, rxq[u].size(), 1);
    if (rxq[u].size() > 0) begin
      got = rxq[u].pop_front();
      chk({tag, ".data"}, got & 'h1FF, data & ((1 << DBW[u]) - 1));
      chk({tag, ".ferr"}, (got >> 9) & 1, int'(efe));
      chk({tag, ".perr"}, (got >> 10) & 1, int'(epe));
    end
  endtask

  task automatic run_random(input int u, input int nframes);
    int data;
    bit flip;
    bit bad;
    int bidx;
    for (int i = 0; i < nframes; i++) begin
      data = int'($urandom_range(0, (1 << DBW[u]) - 1));
      flip = (PARM[u] != 0) && ($urandom_range(0, 3) == 0);
      bad  = ($urandom_range(0, 4) == 0);
      bidx = int'($urandom_range(0, STB[u] - 1));
      send_frame(u, data, flip, bad, bidx);
      step(BT[u] * int'($urandom_range(1, 3)));
      expect_frame(u, data, bad, flip, $sformatf("rnd%0d_%0d", u, i));
    end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ov0;
    rst = 1'b1;
    ser = 3'b111;
    rdy = 3'b111;
    step(3);
    chk("rst.valid", int'(vld), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ferr", int'(fe), 0);
    chk("rst.perr", int'(pe), 0);
    chk("rst.ovr", int'(ovr), 0);
    chk("rst.d0", int'(d0), 0);
    chk("rst.d2", int'(d2), 0);
    rst = 1'b0;
    step(5);

    // Clean 8N1 word.
    send_frame(0, 'hA5, 1'b0, 1'b0, 0);
    step(BT[0]);
    expect_frame(0, 'hA5, 1'b0, 1'b0, "a5");

    // Even parity: wrong parity bit, then the correct one.
    send_frame(1, 'h3C, 1'b1, 1'b0, 0);
    step(BT[1]);
    expect_frame(1, 'h3C, 1'b0, 1'b1, "par_bad");
    send_frame(1, 'h3C, 1'b0, 1'b0, 0);
    step(BT[1]);
    expect_frame(1, 'h3C, 1'b0, 1'b0, "par_ok");

    // Framing error followed by a clean frame.
    send_frame(0, 'h55, 1'b0, 1'b1, 0);
    step(BT[0]);
    expect_frame(0, 'h55, 1'b1, 1'b0, "stop_bad");
    send_frame(0, 'h12, 1'b0, 1'b0, 0);
    step(BT[0]);
    expect_frame(0, 'h12, 1'b0, 1'b0, "after_ferr");

    // Short low glitch is a false start.
    ser[0] = 1'b0;
    step(12);
    ser[0] = 1'b1;
    chk("glitch.busy_hi", int'(busy[0]), 1);
    step(BT[0] * 3);
    chk("glitch.busy_lo", int'(busy[0]), 0);
    chk("glitch.nodata", rxq[0].size(), 0);

    // Overrun: second frame dropped while the first is held.
    ov0 = ovr_cnt[0];
    rdy[0] = 1'b0;
    send_frame(0, 'h11, 1'b0, 1'b0, 0);
    step(BT[0]);
    send_frame(0, 'h22, 1'b0, 1'b0, 0);
    step(BT[0] * 2);
    chk("ovr.pulses", ovr_cnt[0] - ov0, 1);
    chk("ovr.valid", int'(vld[0]), 1);
    chk("ovr.data", int'(d0), 'h11);
    rdy[0] = 1'b1;
    step(4);
    expect_frame(0, 'h11, 1'b0, 1'b0, "ovr_drain");
    step(BT[0] * 4);
    chk("ovr.no22", rxq[0].size(), 0);

    // Reset in the middle of the data bits of 0x77.
    ser[0] = 1'b0;
    step(BT[0]);
    for (int i = 0; i < 4; i++) begin
      ser[0] = 1'((8'h77 >> i) & 1);
      step(BT[0]);
    end
    rst = 1'b1;
    ser[0] = 1'b1;
    step(3);
    chk("midrst.busy", int'(busy[0]), 0);
    chk("midrst.valid", int'(vld[0]), 0);
    rst = 1'b0;
    step(BT[0] * 2);
    chk("midrst.nodata", rxq[0].size(), 0);
    send_frame(0, 'h0F, 1'b0, 1'b0, 0);
    step(BT[0]);
    expect_frame(0, 'h0F, 1'b0, 1'b0, "after_rst");

    // 7 data bits, odd parity, two stop bits.
    send_frame(2, 'h5A, 1'b0, 1'b0, 0);
    step(BT[2]);
    expect_frame(2, 'h5A, 1'b0, 1'b0, "7o2");

    // Break: line held low for many bit times gives exactly one errored zero word.
    ser[0] = 1'b0;
    step(BT[0] * 20);
    ser[0] = 1'b1;
    step(BT[0] * 2);
    expect_frame(0, 0, 1'b1, 1'b0, "break");
    step(BT[0] * 4);
    chk("break.single", rxq[0].size(), 0);

    // Randomised traffic on all three receivers at once.
    fork
      run_random(0, 40);
      run_random(1, 40);
      run_random(2, 40);
    join
    chk("end.ovr0", ovr_cnt[0] - ov0, 1);
    chk("end.ovr12", ovr_cnt[1] + ovr_cnt[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
